// File: rtl/median_window_3x3.sv
// Streaming 3x3 neighbourhood generator feeding the median sorter network.
// Two line buffers plus a 3x3 shift window; one registered window per beat.
module median_window_3x3 #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic [7:0]  in_pixel,
    output logic        out_valid,
    output logic        out_eof,
    output logic [71:0] win
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [7:0]    r_lb0 [IMG_W];
    logic [7:0]    r_lb1 [IMG_W];
    logic [71:0]   r_win;
    logic          r_valid;
    logic          r_eof;

    logic [CW-1:0] w_col;
    logic [CW-1:0] w_col_nxt;
    logic [RW-1:0] w_row;
    logic [RW-1:0] w_row_nxt;
    logic          w_last_col;
    logic          w_last_row;
    logic [7:0]    w_up1;
    logic [7:0]    w_up2;
    logic [71:0]   w_win_nxt;

    // in_sof restarts the frame at (0,0) on the beat that carries it
    always_comb begin
        w_col      = in_sof ? '0 : r_col;
        w_row      = in_sof ? '0 : r_row;
        w_last_col = (w_col == COL_LAST);
        w_last_row = (w_row == ROW_LAST);
        w_col_nxt  = w_col + CW'(1);
        w_row_nxt  = w_row;
        if (w_last_col) begin
            w_col_nxt = '0;
            w_row_nxt = w_last_row ? '0 : w_row + RW'(1);
        end
    end

    always_comb begin
        w_up2     = r_lb1[w_col];
        w_up1     = r_lb0[w_col];
        w_win_nxt = {in_pixel, r_win[71:64], r_win[63:56],
                     w_up1,    r_win[47:40], r_win[39:32],
                     w_up2,    r_win[23:16], r_win[15:8]};
    end

    // Line buffers are never reset; valid gating hides stale contents
    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_lb1[w_col] <= r_lb0[w_col];
            r_lb0[w_col] <= in_pixel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col   <= '0;
            r_row   <= '0;
            r_win   <= '0;
            r_valid <= 1'b0;
            r_eof   <= 1'b0;
        end else if (in_valid) begin
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_win   <= w_win_nxt;
            r_valid <= (w_row >= RW'(2)) && (w_col >= CW'(2));
            r_eof   <= w_last_row && w_last_col;
        end else begin
            r_valid <= 1'b0;
            r_eof   <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_eof   = r_eof;
    assign win       = r_win;

endmodule

// File: tb/tb_median_window_3x3.sv
// Bench for median_window_3x3: directed 4x4 frames and random 7x5 frames
// checked against an image-array neighbourhood model.
module tb_median_window_3x3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_v = 1'b0, a_s = 1'b0;
    logic [7:0]  a_p = '0;
    logic        a_ov, a_oe;
    logic [71:0] a_w;
    logic        b_v = 1'b0, b_s = 1'b0;
    logic [7:0]  b_p = '0;
    logic        b_ov, b_oe;
    logic [71:0] b_w;

    median_window_3x3 #(.IMG_W(4), .IMG_H(4)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_v), .in_sof(a_s), .in_pixel(a_p),
        .out_valid(a_ov), .out_eof(a_oe), .win(a_w)
    );

    median_window_3x3 #(.IMG_W(7), .IMG_H(5)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_v), .in_sof(b_s), .in_pixel(b_p),
        .out_valid(b_ov), .out_eof(b_oe), .win(b_w)
    );

    always #5 clk = ~clk;

    int          npass = 0;
    int          nfail = 0;
    int          ntot  = 0;
    int          W [2] = '{4, 7};
    int          H [2] = '{4, 5};
    int          mrow [2];
    int          mcol [2];
    bit          hold_ok [2];
    logic [71:0] last_exp [2];
    int          img [2][8][8];
    int          wcnt = 0;
    int          ecnt = 0;
    logic [71:0] obs_win;

    task automatic chk(string tag, logic [71:0] obs, logic [71:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        a_v = 1'b0; a_s = 1'b0; a_p = '0;
        b_v = 1'b0; b_s = 1'b0; b_p = '0;
    endtask

    task automatic model_clear();
        for (int s = 0; s < 2; s++) begin
            mrow[s] = 0; mcol[s] = 0;
            hold_ok[s] = 1'b0; last_exp[s] = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("rst_valid_a", 72'(a_ov), 72'(0));
        chk("rst_eof_a", 72'(a_oe), 72'(0));
        chk("rst_win_a", a_w, 72'(0));
        chk("rst_valid_b", 72'(b_ov), 72'(0));
        chk("rst_win_b", b_w, 72'(0));
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic step(int s, bit v, bit sof, logic [7:0] pix);
        int r, c;
        bit ev, ee;
        logic [71:0] ew;
        logic ov, oe;
        logic [71:0] ow;
        ev = 1'b0; ee = 1'b0; ew = '0;
        @(negedge clk);
        idle_inputs();
        if (s == 0) begin a_v = v; a_s = sof; a_p = pix; end
        else        begin b_v = v; b_s = sof; b_p = pix; end
        if (v) begin
            r = sof ? 0 : mrow[s];
            c = sof ? 0 : mcol[s];
            img[s][r][c] = int'(pix);
            if (r >= 2 && c >= 2) begin
                ev = 1'b1;
                ee = (r == H[s] - 1) && (c == W[s] - 1);
                for (int rr = 0; rr < 3; rr++)
                    for (int cc = 0; cc < 3; cc++)
                        ew[8*(3*rr+cc) +: 8] = 8'(img[s][r-2+rr][c-2+cc]);
            end
            c++;
            if (c == W[s]) begin
                c = 0; r++;
                if (r == H[s]) r = 0;
            end
            mrow[s] = r; mcol[s] = c;
        end
        @(posedge clk);
        #1;
        ov = (s == 0) ? a_ov : b_ov;
        oe = (s == 0) ? a_oe : b_oe;
        ow = (s == 0) ? a_w  : b_w;
        obs_win = ow;
        if (ov === 1'b1) wcnt++;
        if (oe === 1'b1) ecnt++;
        chk("valid", 72'(ov), 72'(ev));
        if (ev) begin
            chk("win", ow, ew);
            chk("eof", 72'(oe), 72'(ee));
            last_exp[s] = ew;
            hold_ok[s]  = 1'b1;
        end else begin
            chk("eof_idle", 72'(oe), 72'(0));
            if (!v && hold_ok[s]) chk("hold", ow, last_exp[s]);
            if (v) hold_ok[s] = 1'b0;
        end
    endtask

    task automatic frame(int s, int base, bit rnd, bit sof, int gaps, int exp_n);
        int n0, e0;
        logic [7:0] pix;
        n0 = wcnt; e0 = ecnt;
        for (int i = 0; i < W[s] * H[s]; i++) begin
            if (gaps == 1) step(s, 1'b0, 1'b0, 8'h00);
            if (gaps == 2 && $urandom_range(0, 2) == 0)
                step(s, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
            pix = rnd ? 8'($urandom) : 8'(base + i);
            step(s, 1'b1, sof && (i == 0), pix);
        end
        step(s, 1'b0, 1'b0, 8'h00);
        chk("nwin", 72'(wcnt - n0), 72'(exp_n));
        chk("neof", 72'(ecnt - e0), 72'(1));
    endtask

    initial begin
        int n0;
        model_clear();
        do_reset();

        // full 4x4 frame, pixels 0..15
        n0 = wcnt;
        for (int i = 0; i < 16; i++) begin
            step(0, 1'b1, i == 0, 8'(i));
            if (i == 10)
                chk("first_win", obs_win, 72'h0a_09_08_06_05_04_02_01_00);
            if (i == 15)
                chk("last_win", obs_win, 72'h0f_0e_0d_0b_0a_09_07_06_05);
        end
        step(0, 1'b0, 1'b0, 8'h00);
        chk("t1_nwin", 72'(wcnt - n0), 72'(4));

        // same frame with gaps every other cycle
        frame(0, 0, 1'b0, 1'b0, 1, 4);

        // back-to-back frames, no sof on the second
        frame(0, 0, 1'b0, 1'b0, 0, 4);
        frame(0, 100, 1'b0, 1'b0, 0, 4);

        // abandon a partial frame with sof
        n0 = wcnt;
        for (int i = 0; i < 7; i++) step(0, 1'b1, 1'b0, 8'(i));
        chk("abandon_nwin", 72'(wcnt - n0), 72'(0));
        frame(0, 200, 1'b0, 1'b1, 0, 4);

        // reset after pixel 9
        n0 = wcnt;
        for (int i = 0; i < 10; i++) step(0, 1'b1, 1'b0, 8'(30 + i));
        do_reset();
        frame(0, 50, 1'b0, 1'b0, 0, 4);
        chk("rst_frame_nwin", 72'(wcnt - n0), 72'(4));

        // random 7x5 frames
        frame(1, 0, 1'b1, 1'b1, 2, 15);
        frame(1, 0, 1'b1, 1'b0, 2, 15);
        frame(1, 0, 1'b1, 1'b0, 0, 15);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
